// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and default baud constants.
// Kept separate so the receiver can import the same package.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } tx_state_t;

  // 100 MHz system clock divided down to 115200 baud.
  localparam int CLKS_PER_BIT_115200 = 868;

endpackage

// File: rtl/uart_baud_cnt.sv
// Per-bit baud counter: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// pre_tick marks the cycle before the terminal count so that callers can register outputs that land on it.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick,
  output logic pre_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] PRE_LAST_CNT = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] cnt;

  // The terminal compare restarts the count, so a non-power-of-two CLKS_PER_BIT never
  // relies on the counter overflowing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear || (cnt == LAST_CNT)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_tick = (cnt == LAST_CNT);
  assign pre_tick = (cnt == PRE_LAST_CNT);

endmodule

// File: rtl/uart_tx.sv
// UART transmit serializer: pops bytes from the TX FIFO and sends 8N1/8N2 frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and the stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_DATA_BIT = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] LAST_STOP_BIT = BIT_W'(STOP_BITS - 1);

  tx_state_t             state;
  tx_state_t             state_d;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_d;
  logic [BIT_W-1:0]      bit_cnt;
  logic [BIT_W-1:0]      bit_cnt_d;
  logic                  tx_d;
  logic                  rd_en_d;
  logic                  busy_d;
  logic                  done_d;
  logic                  baud_clear;
  logic                  bit_tick;
  logic                  pre_tick;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q;
  logic                  parity_d;
`endif

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (baud_clear),
    .bit_tick(bit_tick),
    .pre_tick(pre_tick)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d    = state;
    shift_d    = shift_reg;
    bit_cnt_d  = bit_cnt;
    rd_en_d    = 1'b0;
    done_d     = 1'b0;
    baud_clear = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    case (state)
      IDLE: begin
        baud_clear = 1'b1;
        if (tx_en && !fifo_empty) begin
          rd_en_d = 1'b1;
          state_d = FETCH;
        end
      end

      // The FIFO output register updates at the end of this cycle.
      FETCH: begin
        baud_clear = 1'b1;
        state_d    = LOAD;
      end

      LOAD: begin
        baud_clear = 1'b1;
        shift_d    = fifo_data;
        bit_cnt_d  = '0;
`ifdef UART_TX_PARITY_EN
        parity_d   = ^fifo_data;
`endif
        state_d    = START;
      end

      START: begin
        if (bit_tick) begin
          state_d = DATA;
        end
      end

      DATA: begin
        if (bit_tick) begin
          if (bit_cnt == LAST_DATA_BIT) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt + 1'b1;
            shift_d   = shift_reg >> 1;
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          state_d = STOP;
        end
      end
`endif

      // tx_done is registered, so it is raised one cycle ahead of the final stop-bit cycle.
      STOP: begin
        done_d = pre_tick && (bit_cnt == LAST_STOP_BIT);
        if (bit_tick) begin
          if (bit_cnt == LAST_STOP_BIT) begin
            bit_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            bit_cnt_d = bit_cnt + 1'b1;
          end
        end
      end

      default: begin
        baud_clear = 1'b1;
        bit_cnt_d  = '0;
        state_d    = IDLE;
      end
    endcase

    // Line level is derived from the next state so the registered tx lines up with state.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      tx         <= 1'b1;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      shift_reg  <= shift_d;
      bit_cnt    <= bit_cnt_d;
      tx         <= tx_d;
      fifo_rd_en <= rd_en_d;
      busy       <= busy_d;
      tx_done    <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

endmodule
